// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the multi-price vending machine slice.
//   - coin value constants (cents)
//   - FSM state encoding
//   - coin value type produced by the edge detector
// ---------------------------------------------------------------------------
package vending_pkg;

    localparam int NICKEL_C  = 5;
    localparam int DIME_C    = 10;
    localparam int QUARTER_C = 25;

    // Wide enough for the largest single coin (25 cents).
    localparam int COIN_W = 5;
    typedef logic [COIN_W-1:0] coin_val_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

endpackage

// File: rtl/vending_machine_multi_if.sv
// ---------------------------------------------------------------------------
// vending_machine_multi_if
// Bundles the coin-acceptor side and the dispenser/hopper side of the
// vending machine.
//   master : drives coins, item select and cancel; observes the outputs
//   slave  : the vending machine itself
// Signals:
//   nickel/dime/quarter  coin-present levels
//   sel                  item index
//   cancel               refund request (level)
//   credit               current credit in cents
//   candy                one-cycle vend pulse
//   nickel_out/dime_out  one-cycle change pulses
//   coin_reject          one-cycle pulse when a coin is refused
//   busy                 high while vending or returning change
// ---------------------------------------------------------------------------
interface vending_machine_multi_if #(
    parameter int SEL_W    = 2,
    parameter int CREDIT_W = 7
);
    logic                nickel;
    logic                dime;
    logic                quarter;
    logic [SEL_W-1:0]    sel;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                candy;
    logic                nickel_out;
    logic                dime_out;
    logic                coin_reject;
    logic                busy;

    modport master (
        output nickel, dime, quarter, sel, cancel,
        input  credit, candy, nickel_out, dime_out, coin_reject, busy
    );

    modport slave (
        input  nickel, dime, quarter, sel, cancel,
        output credit, candy, nickel_out, dime_out, coin_reject, busy
    );
endinterface

// File: rtl/coin_edge_detect.sv
// ---------------------------------------------------------------------------
// coin_edge_detect
// Rising-edge detection of the three coin-present levels against a
// registered copy, so a coin held high counts once.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   nickel, dime, quarter coin-present levels
//   coin_value            value of the single detected coin (0 otherwise)
//   coin_one              exactly one coin edge this cycle
//   coin_multi            two or more coin edges this cycle
// ---------------------------------------------------------------------------
module coin_edge_detect
    import vending_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      nickel,
    input  logic      dime,
    input  logic      quarter,
    output coin_val_t coin_value,
    output logic      coin_one,
    output logic      coin_multi
);

    logic [2:0] coins;
    logic [2:0] prev;
    logic [2:0] edges;

    assign coins = {quarter, dime, nickel};

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= '0;
        else        prev <= coins;
    end

    assign edges = coins & ~prev;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign coin_multi = (edges & (edges - 3'd1)) != 3'd0;
    assign coin_one   = (edges != 3'd0) && !coin_multi;

    always_comb begin
        // NOTE: default first so no path through the case leaves coin_value
        // unassigned, which would otherwise infer a latch.
        coin_value = '0;
        case (edges)
            3'b001:  coin_value = COIN_W'(NICKEL_C);
            3'b010:  coin_value = COIN_W'(DIME_C);
            3'b100:  coin_value = COIN_W'(QUARTER_C);
            default: coin_value = '0;
        endcase
    end

endmodule

// File: rtl/vending_machine_multi.sv
// ---------------------------------------------------------------------------
// vending_machine_multi
// Coin vending FSM with 2^SEL_W item prices: price(i) = BASE_PRICE +
// i*PRICE_STEP. Accepts one coin per cycle, vends once credit covers the
// price latched at the first coin of a transaction, then returns change one
// coin per cycle. Cancel in IDLE refunds the whole credit.
// Optional build macro: DIME_CHANGE_EN -- change is paid with dimes while
// credit >= 10, otherwise nickels only and dime_out stays 0.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    vending_machine_multi_if.slave (coins, sel, cancel, credit,
//          candy, nickel_out, dime_out, coin_reject, busy)
// ---------------------------------------------------------------------------
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int BASE_PRICE = 25,
    parameter int PRICE_STEP = 10,
    parameter int SEL_W      = 2,
    parameter int CREDIT_W   = 7
) (
    input logic                    clk,
    input logic                    reset,
    vending_machine_multi_if.slave bus
);

    localparam int MAX_CREDIT = BASE_PRICE + ((1 << SEL_W) - 1) * PRICE_STEP + QUARTER_C;

    generate
        if (MAX_CREDIT > (1 << CREDIT_W) - 1) begin : g_bad_params
            $error("vending_machine_multi: CREDIT_W too narrow for the price range");
        end
    endgenerate

    function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
        return CREDIT_W'(BASE_PRICE + int'(idx) * PRICE_STEP);
    endfunction

    state_t              state, state_next;
    logic [CREDIT_W-1:0] credit_q, credit_next;
    logic [CREDIT_W-1:0] price_q, price_next;
    logic                reject_q, reject_next;

    coin_val_t           coin_value;
    logic                coin_one;
    logic                coin_multi;
    logic                coin_any;
    logic [CREDIT_W-1:0] credit_sum;
    logic [CREDIT_W-1:0] eff_price;
    logic                candy_o;
    logic                nickel_o;
    logic                dime_o;

    coin_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .nickel     (bus.nickel),
        .dime       (bus.dime),
        .quarter    (bus.quarter),
        .coin_value (coin_value),
        .coin_one   (coin_one),
        .coin_multi (coin_multi)
    );

    assign coin_any   = coin_one | coin_multi;
    assign credit_sum = credit_q + CREDIT_W'(coin_value);

    // The price is fixed by sel at the first coin of a transaction (credit 0);
    // later sel changes do not move the target.
    assign eff_price = (credit_q == '0) ? price_of(bus.sel) : price_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            credit_q <= '0;
            price_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            state    <= state_next;
            credit_q <= credit_next;
            price_q  <= price_next;
            reject_q <= reject_next;
        end
    end

    always_comb begin
        state_next  = state;
        credit_next = credit_q;
        price_next  = price_q;
        reject_next = 1'b0;
        candy_o     = 1'b0;
        nickel_o    = 1'b0;
        dime_o      = 1'b0;

        case (state)
            IDLE: begin
                if (coin_multi) begin
                    reject_next = 1'b1;
                end else if (coin_one) begin
                    credit_next = credit_sum;
                    price_next  = eff_price;
                    if (credit_sum >= eff_price) state_next = VEND;
                end else if (bus.cancel && credit_q != '0) begin
                    state_next = CHANGE;
                end
            end

            VEND: begin
                reject_next = coin_any;
                candy_o     = 1'b1;
                credit_next = credit_q - price_q;
                state_next  = (credit_q != price_q) ? CHANGE : IDLE;
            end

            CHANGE: begin
                reject_next = coin_any;
`ifdef DIME_CHANGE_EN
                if (credit_q >= CREDIT_W'(DIME_C)) begin
                    dime_o      = 1'b1;
                    credit_next = credit_q - CREDIT_W'(DIME_C);
                end else begin
                    nickel_o    = 1'b1;
                    credit_next = credit_q - CREDIT_W'(NICKEL_C);
                end
`else
                nickel_o    = 1'b1;
                credit_next = credit_q - CREDIT_W'(NICKEL_C);
`endif
                if (credit_next == '0) state_next = IDLE;
            end

            default: begin
                state_next  = IDLE;
                credit_next = '0;
            end
        endcase
    end

    // Pulses decode straight from the state so an asynchronous reset clears
    // them immediately.
    assign bus.credit      = credit_q;
    assign bus.candy       = candy_o;
    assign bus.nickel_out  = nickel_o;
    assign bus.dime_out    = dime_o;
    assign bus.coin_reject = reject_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_vending_machine_multi.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_multi
// Directed bench for vending_machine_multi with default parameters
// (prices 25/35/45/55). Expected values are hand-computed; the
// DIME_CHANGE_EN build selects the alternative change expectations.
// ---------------------------------------------------------------------------
module tb_vending_machine_multi;

    logic clk = 1'b0;
    logic reset = 1'b0;

    vending_machine_multi_if #(.SEL_W(2), .CREDIT_W(7)) vif ();

    vending_machine_multi #(
        .BASE_PRICE (25),
        .PRICE_STEP (10),
        .SEL_W      (2),
        .CREDIT_W   (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the given coins for one clock, then drop them.
    task automatic pulse(input logic n, input logic d, input logic q);
        vif.nickel  = n;
        vif.dime    = d;
        vif.quarter = q;
        tick();
        vif.nickel  = 1'b0;
        vif.dime    = 1'b0;
        vif.quarter = 1'b0;
    endtask

    // Count output pulses from the current cycle until busy drops.
    task automatic drain(output int n_nick, output int n_dime, output int n_candy);
        int budget;
        budget  = 40;
        n_nick  = 0;
        n_dime  = 0;
        n_candy = 0;
        while (vif.busy && budget > 0) begin
            n_nick  += int'(vif.nickel_out);
            n_dime  += int'(vif.dime_out);
            n_candy += int'(vif.candy);
            tick();
            budget--;
        end
        check("drain_in_budget", 32'(budget > 0), 1);
    endtask

    int nn, nd, nc;

    initial begin
        vif.nickel  = 1'b0;
        vif.dime    = 1'b0;
        vif.quarter = 1'b0;
        vif.sel     = '0;
        vif.cancel  = 1'b0;
        #12;
        check("rst_credit", 32'(vif.credit), 0);
        check("rst_candy",  32'(vif.candy), 0);
        check("rst_busy",   32'(vif.busy), 0);
        check("rst_reject", 32'(vif.coin_reject), 0);
        check("rst_nickel_out", 32'(vif.nickel_out), 0);
        check("rst_dime_out",   32'(vif.dime_out), 0);
        reset = 1'b1;
        tick();

        // Cancel with zero credit is ignored.
        vif.cancel = 1'b1;
        tick();
        check("cancel_zero_busy", 32'(vif.busy), 0);
        vif.cancel = 1'b0;

        // Test 1: sel=0, nickel, dime, dime -> exact price, no change.
        vif.sel = 2'd0;
        pulse(1, 0, 0);
        check("t1_credit5", 32'(vif.credit), 5);
        pulse(0, 1, 0);
        check("t1_credit15", 32'(vif.credit), 15);
        tick();
        pulse(0, 1, 0);
        check("t1_credit25", 32'(vif.credit), 25);
        check("t1_candy", 32'(vif.candy), 1);
        check("t1_busy", 32'(vif.busy), 1);
        tick();
        check("t1_credit0", 32'(vif.credit), 0);
        check("t1_candy_off", 32'(vif.candy), 0);
        check("t1_no_change", 32'(vif.nickel_out), 0);
        check("t1_idle", 32'(vif.busy), 0);

        // Test 2: sel=0, dime then quarter -> 35, vend, 10 change.
        pulse(0, 1, 0);
        check("t2_credit10", 32'(vif.credit), 10);
        pulse(0, 0, 1);
        check("t2_credit35", 32'(vif.credit), 35);
        check("t2_candy", 32'(vif.candy), 1);
        tick();
        check("t2_after_vend", 32'(vif.credit), 10);
        drain(nn, nd, nc);
`ifdef DIME_CHANGE_EN
        check("t2_nickels", 32'(nn), 0);
        check("t2_dimes", 32'(nd), 1);
`else
        check("t2_nickels", 32'(nn), 2);
        check("t2_dimes", 32'(nd), 0);
`endif
        check("t2_credit_end", 32'(vif.credit), 0);

        // Test 3: sel=3 latched at first quarter; sel moved to 0 afterwards.
        vif.sel = 2'd3;
        pulse(0, 0, 1);
        check("t3_credit25", 32'(vif.credit), 25);
        check("t3_no_vend25", 32'(vif.candy), 0);
        vif.sel = 2'd0;
        tick();
        pulse(0, 0, 1);
        check("t3_credit50", 32'(vif.credit), 50);
        check("t3_no_vend50", 32'(vif.candy), 0);
        pulse(0, 1, 0);
        check("t3_credit60", 32'(vif.credit), 60);
        drain(nn, nd, nc);
        check("t3_candy_cnt", 32'(nc), 1);
        check("t3_nickels", 32'(nn), 1);
        check("t3_dimes", 32'(nd), 0);
        check("t3_credit_end", 32'(vif.credit), 0);

        // Test 4: simultaneous coins rejected; held dime counts once.
        vif.sel = 2'd1;
        pulse(1, 0, 0);
        check("t4_credit5", 32'(vif.credit), 5);
        tick();
        pulse(1, 1, 0);
        check("t4_reject", 32'(vif.coin_reject), 1);
        check("t4_credit_kept", 32'(vif.credit), 5);
        tick();
        check("t4_reject_off", 32'(vif.coin_reject), 0);
        vif.dime = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_held_dime", 32'(vif.credit), 15);
        end
        vif.dime = 1'b0;
        tick();

        // Test 5: cancel refunds 15; quarter during CHANGE is rejected.
        vif.cancel = 1'b1;
        tick();
        vif.cancel = 1'b0;
        check("t5_busy", 32'(vif.busy), 1);
        check("t5_credit15", 32'(vif.credit), 15);
`ifdef DIME_CHANGE_EN
        check("t5_first_dime", 32'(vif.dime_out), 1);
`else
        check("t5_first_nickel", 32'(vif.nickel_out), 1);
`endif
        pulse(0, 0, 1);
        check("t5_reject", 32'(vif.coin_reject), 1);
`ifdef DIME_CHANGE_EN
        check("t5_credit_mid", 32'(vif.credit), 5);
`else
        check("t5_credit_mid", 32'(vif.credit), 10);
`endif
        drain(nn, nd, nc);
`ifdef DIME_CHANGE_EN
        check("t5_rest_nickels", 32'(nn), 1);
`else
        check("t5_rest_nickels", 32'(nn), 2);
`endif
        check("t5_rest_dimes", 32'(nd), 0);
        check("t5_no_candy", 32'(nc), 0);
        check("t5_credit_end", 32'(vif.credit), 0);

        // Test 6: asynchronous reset in the middle of CHANGE.
        vif.sel = 2'd0;
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        check("t6_candy", 32'(vif.candy), 1);
        tick();
        check("t6_change10", 32'(vif.credit), 10);
        check("t6_busy", 32'(vif.busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_credit", 32'(vif.credit), 0);
        check("t6_rst_busy", 32'(vif.busy), 0);
        check("t6_rst_nickel_out", 32'(vif.nickel_out), 0);
        check("t6_rst_dime_out", 32'(vif.dime_out), 0);
        check("t6_rst_candy", 32'(vif.candy), 0);
        reset = 1'b1;
        pulse(1, 0, 0);
        check("t6_post_credit5", 32'(vif.credit), 5);
        check("t6_post_idle", 32'(vif.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
